sram_1rw1r_param: RTL and testbench
===================================

Name: sram_1rw1r_param

Overview:
Parametrised synchronous SRAM macro model. It succeeds the fixed 32x128 single-port part and sits in the same SRAM benchmark family.
- Port 0 is read/write with a per-byte write mask; port 1 is read-only.
- Both read outputs are registered.
- A built-in clear engine zeroes the whole array after reset, so contents are deterministic for benches and downstream logic.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 7, address width; DEPTH = 1 << ADDR_WIDTH
NUM_WMASKS, DATA_WIDTH/8, number of byte-lane write-mask bits (derived, not overridden)

Ports:
clk0  in  1  single clock for both ports and the clear engine
rst0  in  1  reset, asynchronous, active-high
csb0  in  1  port 0 chip select, active-low
web0  in  1  port 0 write enable, active-low (1 = read)
wmask0  in  NUM_WMASKS  port 0 byte-lane write mask, bit i enables din0[8i+7:8i]
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 registered read data
csb1  in  1  port 1 chip select, active-low
addr1  in  ADDR_WIDTH  port 1 address
dout1  out  DATA_WIDTH  port 1 registered read data
init_busy  out  1  high while reset is asserted or the clear sweep is running; accesses are ignored while high

Behaviour:
- Reset (asynchronous, rst0=1):
  - dout0=0, dout1=0, init_busy=1.
  - FSM goes to RST; the clear address counter goes to 0.
  - Array contents are not touched asynchronously.
- FSM states RST -> CLEAR -> READY:
  - RST -> CLEAR on the first clk0 edge with rst0=0.
  - CLEAR writes 0 to mem[clr_addr] each edge, then increments clr_addr. At clr_addr == DEPTH-1 it writes and moves to READY.
  - init_busy falls on the edge entering READY. With rst0 released before edge 0, init_busy is low after edge DEPTH+1.
  - READY is terminal until the next reset.
- Reset mid-CLEAR: FSM returns to RST immediately. The sweep restarts from address 0 after release; partial clears are never relied on.
- Port 0 in READY, on the clk0 rising edge:
  - csb0=0, web0=0: write lanes where wmask0[i]=1; masked lanes keep their old value. dout0 holds its previous value.
  - csb0=0, web0=1: dout0 <= mem[addr0]. Data is visible after the edge, i.e. 1-cycle latency.
  - csb0=1: no access; dout0 holds.
- Port 1 in READY, on the clk0 rising edge:
  - csb1=0: dout1 <= mem[addr1], 1-cycle latency.
  - csb1=1: dout1 holds.
- Collision (port 0 write and port 1 read to the same address on the same edge):
  - Read-first: dout1 returns the pre-write word.
  - The write completes normally; the next port 1 read returns the new word.
- Port 0 write with wmask0 = 0: no array change, no error.
- Accesses while init_busy=1 are ignored; dout0 and dout1 stay 0.
- Addresses cover the full 0..DEPTH-1 range. There is no out-of-range case and no wrap logic beyond the clear counter, which stops at DEPTH-1.

Optional Feature:
Macro SRAM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane, alongside each lane.
  - It is updated per lane on masked writes and set to 0 by the clear sweep, which is consistent with all-zero data.
  - An extra output, parity_err (1 bit), is registered with dout0/dout1. It pulses high for one cycle when either port's read data fails its stored parity; reset value 0.
  - A hierarchical force on a stored parity bit is how benches inject errors.
- When undefined: no parity storage and no parity_err port; the block is otherwise identical.

Decomposition:
Shared package sram_pkg holds:
- the FSM state typedef (ST_RST, ST_CLEAR, ST_READY);
- the byte-lane width constant (8);
- the function computing NUM_WMASKS from DATA_WIDTH.

One sub-module, sram_clear_fsm, owns the state register, the clr_addr counter and init_busy. Its outputs are clr_we, clr_addr and busy, which the array's write-port mux consumes.

Test Plan:
- Release rst0 at defaults -> init_busy stays high for 129 edges, then falls; port 1 reads of addresses 0, 64 and 127 return 0x00000000.
- Port 0 writes 0xFACECAFE to address 10 with wmask0=4'hF, then reads address 10 -> dout0 = 0xFACECAFE one cycle after the read edge; dout1 for address 10 matches.
- Port 0 writes 0xDEADBEEF to address 10 with wmask0=4'b0011 -> readback 0xFACEBEEF.
- Same edge: port 0 writes 0x12345678 to address 12 while port 1 reads address 12 (previously 0) -> dout1 = 0x00000000; next port 1 read = 0x12345678.
- Assert rst0 at clear cycle 50 after writing, then release -> dout0/dout1 go to 0 asynchronously; the sweep restarts (another 129 edges busy); port 0 accesses during busy are ignored; address 10 reads 0 afterwards.
- With SRAM_PARITY_EN: write 0xA5A5A5A5, force lane-0 parity inverted, read -> parity_err=1 for exactly one cycle; a clean read -> parity_err=0.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the 1RW+1R SRAM model
package sram_pkg;

  // Clear-engine states: held in reset, sweeping zeros, then serving accesses.
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } sram_state_e;

  localparam int LANE_W = 8;

  // One write-mask bit per byte lane.
  function automatic int calc_num_wmasks(input int data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// rtl/sram_clear_fsm.sv - post-reset zeroing sweep sequencer for the SRAM array
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  sram_state_e           state;
  sram_state_e           state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  // State and sweep address; reset parks the sweep at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RST;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= addr_nxt;
    end
  end

  // Sweep one word per edge; the counter stops on the last address as READY is entered.
  always_comb begin
    state_nxt = state;
    addr_nxt  = clr_addr;
    clr_we    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_RST: begin
        state_nxt = ST_CLEAR;
        addr_nxt  = '0;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = ST_READY;
        end else begin
          addr_nxt = clr_addr + 1'b1;
        end
      end
      ST_READY: begin
        busy = 1'b0;
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised 1RW+1R synchronous SRAM with clear engine; optional SRAM_PARITY_EN adds per-lane parity and parity_err
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 7,
  localparam int NUM_WMASKS = calc_num_wmasks(DATA_WIDTH)
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_busy
`ifdef SRAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  rd0;
  logic                  wr0;
  logic                  rd1;

  sram_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_fsm (
    .clk     (clk0),
    .rst     (rst0),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (init_busy)
  );

  assign rd0 = !init_busy && !csb0 && web0;
  assign wr0 = !init_busy && !csb0 && !web0;
  assign rd1 = !init_busy && !csb1;

  // Array write port: the clear sweep owns it while busy, port 0 afterwards.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered reads; sampling the pre-edge array gives read-first on collisions.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (rd0) dout0 <= mem[addr0];
      if (rd1) dout1 <= mem[addr1];
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] par_mem [DEPTH];

  // Even parity per byte lane: the stored bit equals the XOR of the lane.
  function automatic logic [NUM_WMASKS-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NUM_WMASKS-1:0] p;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      p[i] = ^d[i*LANE_W +: LANE_W];
    end
    return p;
  endfunction

  // Parity storage tracks the data array lane by lane.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      par_mem[clr_addr] <= '0;
    end else if (wr0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          par_mem[addr0][i] <= ^din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Error flag is aligned with dout0/dout1 and lasts only for the reading cycle.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (rd0 && (lane_parity(mem[addr0]) != par_mem[addr0])) ||
                    (rd1 && (lane_parity(mem[addr1]) != par_mem[addr1]));
    end
  end
`endif

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - directed self-checking bench for sram_1rw1r_param
module tb_sram_1rw1r_param;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic        csb0 = 1'b1;
  logic        web0 = 1'b1;
  logic [3:0]  wmask0 = 4'h0;
  logic [6:0]  addr0 = 7'd0;
  logic [31:0] din0 = 32'h0;
  logic [31:0] dout0;
  logic        csb1 = 1'b1;
  logic [6:0]  addr1 = 7'd0;
  logic [31:0] dout1;
  logic        init_busy;
`ifdef SRAM_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int passed = 0;

  sram_1rw1r_param dut (
    .clk0     (clk0),
    .rst0     (rst0),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .csb1     (csb1),
    .addr1    (addr1),
    .dout1    (dout1),
    .init_busy(init_busy)
`ifdef SRAM_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr0(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    @(posedge clk0); #1;
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic rd0(input logic [6:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    @(posedge clk0); #1;
    csb0 = 1'b1;
    check(tag, dout0, exp);
  endtask

  task automatic rd1(input logic [6:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk0);
    csb1 = 1'b0; addr1 = a;
    @(posedge clk0); #1;
    csb1 = 1'b1;
    check(tag, dout1, exp);
  endtask

  // Counts edges from a negedge release of rst0 until init_busy drops.
  task automatic release_and_count(output int n);
    @(negedge clk0);
    rst0 = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk0); #1;
      n++;
      if (!init_busy) begin
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n;

    #12;
    check("reset_dout0", dout0, 32'h0);
    check("reset_dout1", dout1, 32'h0);
    check("reset_busy", {31'h0, init_busy}, 32'h1);

    release_and_count(n);
    check("clear_edges", n, 32'd129);

    rd1(7'd0,   32'h0, "clr_rd_0");
    rd1(7'd64,  32'h0, "clr_rd_64");
    rd1(7'd127, 32'h0, "clr_rd_127");

    wr0(7'd10, 32'hFACECAFE, 4'hF);
    rd0(7'd10, 32'hFACECAFE, "full_wr_rd0");
    rd1(7'd10, 32'hFACECAFE, "full_wr_rd1");

    wr0(7'd10, 32'hDEADBEEF, 4'b0011);
    rd0(7'd10, 32'hFACEBEEF, "mask_wr_rd0");

    wr0(7'd10, 32'h00000000, 4'h0);
    check("dout0_hold_on_wr", dout0, 32'hFACEBEEF);
    rd0(7'd10, 32'hFACEBEEF, "mask0_noop");

    // Collision: same-edge write on port 0 and read on port 1.
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 7'd12; din0 = 32'h12345678; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 7'd12;
    @(posedge clk0); #1;
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    check("collide_read_first", dout1, 32'h0);
    rd1(7'd12, 32'h12345678, "collide_after");

    // Both ports reading different words on one edge.
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'd12; csb1 = 1'b0; addr1 = 7'd10;
    @(posedge clk0); #1;
    csb0 = 1'b1; csb1 = 1'b1;
    check("dual_rd0", dout0, 32'h12345678);
    check("dual_rd1", dout1, 32'hFACEBEEF);

    @(negedge clk0);
    addr1 = 7'd0;
    @(posedge clk0); #1;
    check("dout1_hold_idle", dout1, 32'hFACEBEEF);

    // Asynchronous reset clears outputs before any clock edge.
    @(negedge clk0);
    rst0 = 1'b1;
    #1;
    check("async_dout0", dout0, 32'h0);
    check("async_dout1", dout1, 32'h0);
    check("async_busy", {31'h0, init_busy}, 32'h1);

    // Release, let the sweep reach cycle 50, then reset again mid-clear.
    @(negedge clk0);
    rst0 = 1'b0;
    repeat (50) @(posedge clk0);
    #1;
    check("busy_mid_clear", {31'h0, init_busy}, 32'h1);
    @(negedge clk0);
    rst0 = 1'b1;
    @(negedge clk0);

    // Hold accesses active throughout the restarted sweep; all must be ignored.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 7'd10; din0 = 32'h55555555; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 7'd12;
    release_and_count(n);
    check("reclear_edges", n, 32'd129);
    check("busy_rd_ignored", dout1, 32'h0);
    check("busy_dout0_zero", dout0, 32'h0);
    rd0(7'd10, 32'h0, "reclear_rd0_10");
    rd1(7'd10, 32'h0, "reclear_rd1_10");
    rd1(7'd12, 32'h0, "reclear_rd1_12");

`ifdef SRAM_PARITY_EN
    wr0(7'd20, 32'hA5A5A5A5, 4'hF);
    rd0(7'd20, 32'hA5A5A5A5, "par_clean_data");
    check("par_clean", {31'h0, parity_err}, 32'h0);
    force dut.par_mem[20][0] = 1'b1;
    rd0(7'd20, 32'hA5A5A5A5, "par_bad_data");
    check("par_err_set", {31'h0, parity_err}, 32'h1);
    @(posedge clk0); #1;
    check("par_err_pulse", {31'h0, parity_err}, 32'h0);
    release dut.par_mem[20][0];
    wr0(7'd21, 32'h0F0F0F01, 4'hF);
    rd1(7'd21, 32'h0F0F0F01, "par_clean2_data");
    check("par_clean2", {31'h0, parity_err}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
